div_seq: RTL and testbench

Sequencer that performs unsigned integer division by repeated subtraction on an internal subtractor SFR (`subSFR`). It loads the dividend, issues one subtract per cycle while the running value is at least the divisor, and counts the subtractions into a quotient. It sits beside the other SFRs as the control block for the subtractor datapath. It presents a start/busy/done handshake to the surrounding controller.

---
 rtl/div_pkg.sv | 16 +
 rtl/subSFR.sv | 31 +++
 rtl/div_seq.sv | 116 +++++++++++
 tb/tb_div_seq.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared constants and state encoding for the repeated-subtraction divider
// Contents:
//   DIV_SIZE    default operand/result width
//   div_state_t sequencer states (IDLE=0, LOAD=1, SUB=2, DONE=3)
package div_pkg;

  localparam int DIV_SIZE = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SUB  = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/subSFR.sv
// rtl/subSFR.sv - subtractor special-function register: load or subtract-in-place
// Ports:
//   clk  rising-edge clock
//   ld   load Q with D (has priority over sub)
//   sub  replace Q with Q - S
//   D    load value
//   S    subtrahend
//   Q    current register value
// No reset input; the owner clears it by loading zero.
module subSFR
  import div_pkg::*;
#(
  parameter int SIZE = DIV_SIZE
) (
  input  logic            clk,
  input  logic            ld,
  input  logic            sub,
  input  logic [SIZE-1:0] D,
  input  logic [SIZE-1:0] S,
  output logic [SIZE-1:0] Q
);

  always_ff @(posedge clk) begin
    if (ld) begin
      Q <= D;
    end else if (sub) begin
      Q <= Q - S;
    end
  end

endmodule

// File: rtl/div_seq.sv
// rtl/div_seq.sv - unsigned divider sequencer driving subSFR by repeated subtraction
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      division request, sampled only when not busy
//   dividend   unsigned dividend, sampled with start
//   divisor    unsigned divisor, sampled with start
//   busy       high while in LOAD or SUB
//   done       one-cycle pulse, results valid from this cycle
//   div_zero   last accepted request had divisor 0
//   quotient   result quotient, held until the next accepted start
//   remainder  result remainder, held until the next accepted start
module div_seq
  import div_pkg::*;
#(
  parameter int SIZE = DIV_SIZE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [SIZE-1:0] dividend,
  input  logic [SIZE-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic            div_zero,
  output logic [SIZE-1:0] quotient,
  output logic [SIZE-1:0] remainder
);

  div_state_t      state;
  logic [SIZE-1:0] dvd_q;
  logic [SIZE-1:0] dsr_q;
  logic [SIZE-1:0] cnt;

  logic            sfr_ld;
  logic            sfr_sub;
  logic [SIZE-1:0] sfr_d;
  logic [SIZE-1:0] sfr_q;
  logic            sfr_ge;

  // The dividend is captured at acceptance so the LOAD cycle is immune to
  // the caller changing its inputs afterwards. During reset the SFR is
  // cleared by loading zero, since it has no reset of its own.
  assign sfr_ld  = rst || (state == LOAD);
  assign sfr_d   = rst ? '0 : dvd_q;
  assign sfr_ge  = (sfr_q >= dsr_q);
  assign sfr_sub = !rst && (state == SUB) && sfr_ge;

  subSFR #(.SIZE(SIZE)) u_sfr (
    .clk (clk),
    .ld  (sfr_ld),
    .sub (sfr_sub),
    .D   (sfr_d),
    .S   (dsr_q),
    .Q   (sfr_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      cnt       <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            dvd_q    <= dividend;
            dsr_q    <= divisor;
            cnt      <= '0;
            div_zero <= (divisor == '0);
            if (divisor != '0) begin
              state <= LOAD;
              busy  <= 1'b1;
            end else begin
              // Divide-by-zero bypasses the datapath entirely.
              state     <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              quotient  <= '1;
              remainder <= dividend;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        LOAD: begin
          state <= SUB;
        end
        SUB: begin
          if (sfr_ge) begin
            cnt <= cnt + SIZE'(1);
          end else begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= cnt;
            remainder <= sfr_q;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - scoreboard testbench for div_seq
module tb_div_seq;

  typedef struct {
    int          acc;
    int          done_cyc;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int   cyc = 0;
  logic rst_s;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  div_seq #(.SIZE(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_s <= rst;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares outputs against the head of the scoreboard each cycle.
  initial begin
    logic exp_busy;
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        if (rst_s === 1'b1) begin
          chk("rst_busy", {31'd0, busy}, 32'd0);
          chk("rst_done", {31'd0, done}, 32'd0);
          chk("rst_div_zero", {31'd0, div_zero}, 32'd0);
          chk("rst_quotient", quotient, 32'd0);
          chk("rst_remainder", remainder, 32'd0);
        end else begin
          exp_busy = 1'b0;
          if (sb.size() > 0 && !sb[0].dz && cyc > sb[0].acc && cyc < sb[0].done_cyc)
            exp_busy = 1'b1;
          chk("busy", {31'd0, busy}, {31'd0, exp_busy});
          if (sb.size() > 0 && sb[0].dz)
            chk("sfr_sub_in_div0", {31'd0, dut.sfr_sub}, 32'd0);
          if (done === 1'b1) begin
            if (sb.size() == 0) begin
              chk("unexpected_done", 32'd1, 32'd0);
            end else begin
              chk("done_cycle", cyc, sb[0].done_cyc);
              chk("quotient", quotient, sb[0].q);
              chk("remainder", remainder, sb[0].r);
              chk("div_zero", {31'd0, div_zero}, {31'd0, sb[0].dz});
              void'(sb.pop_front());
            end
          end else if (sb.size() > 0 && cyc >= sb[0].done_cyc) begin
            chk("missing_done", cyc, sb[0].done_cyc - 1);
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Accept happens at the end of the current cycle (cycle 0 of the request).
  task automatic issue(input logic [31:0] dvd, input logic [31:0] dsr,
                       input logic [31:0] q, input logic [31:0] r,
                       input logic dz, input int lat);
    exp_t e;
    start    = 1'b1;
    dividend = dvd;
    divisor  = dsr;
    e.acc      = cyc;
    e.done_cyc = cyc + lat;
    e.q        = q;
    e.r        = r;
    e.dz       = dz;
    sb.push_back(e);
    step(1);
    start    = 1'b0;
    dividend = 32'hDEAD_BEEF;
    divisor  = 32'h0000_0003;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      step(1);
      n++;
    end
    if (sb.size() != 0) begin
      chk("timeout_waiting_done", sb.size(), 0);
      sb.delete();
    end
    step(2);
  endtask

  initial begin
    int a;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    step(3);
    rst = 1'b0;
    step(1);

    issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 17);
    wait_idle();
    issue(32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 3);
    wait_idle();
    issue(32'd42, 32'd0, 32'hFFFF_FFFF, 32'd42, 1'b1, 1);
    wait_idle();
    issue(32'd255, 32'd16, 32'd15, 32'd15, 1'b0, 18);
    wait_idle();
    issue(32'd0, 32'd3, 32'd0, 32'd0, 1'b0, 3);
    wait_idle();

    // Start while busy is ignored; start in the DONE cycle is accepted.
    a = cyc;
    issue(32'd20, 32'd5, 32'd4, 32'd0, 1'b0, 7);
    step(2);
    start    = 1'b1;
    dividend = 32'd9;
    divisor  = 32'd3;
    step(1);
    start = 1'b0;
    step(a + 7 - cyc);
    issue(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 6);
    wait_idle();

    // Reset mid-operation aborts; a following request completes normally.
    a = cyc;
    issue(32'd1000, 32'd1, 32'd1000, 32'd0, 1'b0, 1003);
    step(a + 50 - cyc);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    sb.delete();
    step(1);
    issue(32'd8, 32'd8, 32'd1, 32'd0, 1'b0, 4);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
